// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizer, oversampling tick, majority-vote FSM.
// Delivers bytes on a valid/ready push port with framing/overrun pulses.
module uart_rx_deserializer #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int BAUD_OS = BAUD_RATE * OVERSAMPLE;
   localparam int DIV     = (CLK_FREQ + BAUD_OS / 2) / BAUD_OS;
   localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int M       = OVERSAMPLE / 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [TW-1:0]          t_cnt;
   logic                   tick;
   logic [SW-1:0]          s_cnt;
   logic [2:0]             state;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic                   samp_a;
   logic                   samp_b;
   logic                   maj;
   logic                   in_frame;
   logic                   decide;
   logic                   start_det;
   logic                   deliver;
   logic                   stop_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rxs       = sync_q[SYNC_STAGES-1];
   assign tick      = (t_cnt == TW'(DIV - 1));
   assign start_det = (state == S_IDLE) && !rxs;

   // Realign the tick phase to the detected start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    t_cnt <= '0;
      else if (start_det || tick) t_cnt <= '0;
      else                        t_cnt <= t_cnt + 1'b1;
   end

   assign maj      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
   assign in_frame = (state == S_START) || (state == S_DATA) ||
                     (state == S_STOP);
   assign decide   = in_frame && tick && (s_cnt == SW'(M + 1));
   assign deliver  = decide && (state == S_STOP) && maj;
   assign stop_bad = decide && (state == S_STOP) && !maj;
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         s_cnt   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         samp_a  <= 1'b1;
         samp_b  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state <= S_START;
                  s_cnt <= '0;
               end
            end
            S_START, S_DATA, S_STOP: begin
               if (tick) begin
                  if (s_cnt == SW'(OVERSAMPLE - 1)) s_cnt <= '0;
                  else                              s_cnt <= s_cnt + 1'b1;
                  if (s_cnt == SW'(M - 1)) samp_a <= rxs;
                  if (s_cnt == SW'(M))     samp_b <= rxs;
               end
               if (decide) begin
                  if (state == S_START) begin
                     if (maj) begin
                        state <= S_IDLE;
                     end else begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                     end
                  end else if (state == S_DATA) begin
                     shreg   <= {maj, shreg[7:1]};
                     bit_idx <= bit_idx + 1'b1;
                     if (bit_idx == 3'd7) state <= S_STOP;
                  end else begin
                     // Leave at stop mid-bit to tolerate baud skew
                     state <= maj ? S_IDLE : S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data    <= '0;
         m_valid   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= deliver && m_valid && !m_ready;
         if (deliver && (!m_valid || m_ready)) begin
            m_data  <= shreg;
            m_valid <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule
